// File: rtl/io_pkg.sv
// Shared IO-page definitions: UART register map, STATUS/CTRL bit positions,
// shifter state encoding and STATUS packing helper.
package io_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVIDER = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_BUSY   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_OVF    = 3;
  localparam int ST_FULL   = 9;
  localparam int ST_LEVEL  = 16;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic       busy;
    logic       empty;
    logic       ovf;
    logic       full;
    logic [7:0] level;
  } tx_status_t;

  function automatic logic [31:0] pack_status(input tx_status_t s);
    logic [31:0] w;
    w              = '0;
    w[ST_BUSY]     = s.busy;
    w[ST_EMPTY]    = s.empty;
    w[ST_OVF]      = s.ovf;
    w[ST_FULL]     = s.full;
    w[ST_LEVEL+:8] = s.level;
    return w;
  endfunction

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with level counter; pointers wrap modulo DEPTH (power of two).
// Flush dominates push; a push while full is ignored.
module io_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO, programmable bit period,
// 8N1/8N2 framing, level interrupt when idle and drained.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 48,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int         LW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  logic wr_data, wr_div, wr_ctrl, rd_en;
  logic flush, ovf_clr;

  assign wr_data = sel & wstrb & (reg_addr == REG_DATA);
  assign wr_div  = sel & wstrb & (reg_addr == REG_DIVIDER);
  assign wr_ctrl = sel & wstrb & (reg_addr == REG_CTRL);
  assign rd_en   = sel & rstrb;
  assign flush   = wr_ctrl & wdata[CTRL_FLUSH];
  assign ovf_clr = wr_ctrl & wdata[CTRL_OVF_CLR];

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  logic [15:0] divider;
  logic        irq_en, ovf;

  logic          fifo_pop, fifo_empty, fifo_full;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;

  io_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_data),
    .wdata  (wdata[7:0]),
    .pop    (fifo_pop),
    .flush  (flush),
    .rdata  (fifo_head),
    .level  (fifo_level),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      divider <= clamp_div(16'(DIV_RESET));
      irq_en  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (wr_div)  divider <= clamp_div(wdata[15:0]);
      if (wr_ctrl) irq_en  <= wdata[CTRL_IRQ_EN];
      // a push into a full FIFO is lost even if the shifter pops this cycle
      if (wr_data && fifo_full) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

  // ---------------- shifter ----------------
  tx_state_e   state_q, state_d;
  logic [15:0] div_q, cnt_q;
  logic [7:0]  shreg_q;
  logic [2:0]  bit_q;
  logic        bit_end, last_data, last_stop, line_d;

  assign bit_end   = (cnt_q == div_q - 16'd1);
  assign last_data = (bit_q == 3'd7);
  assign last_stop = (bit_q == STOP_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= TX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    line_d   = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        line_d = 1'b0;
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        line_d = shreg_q[0];
        if (bit_end && last_data) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end && last_stop) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // txd and irq are registered, so both lag the state by one clk and stay aligned
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q   <= DIV_MIN;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd     <= 1'b1;
      irq     <= 1'b0;
    end else begin
      if (fifo_pop) begin
        shreg_q <= fifo_head;
        div_q   <= divider;
        cnt_q   <= '0;
        bit_q   <= '0;
      end else if (state_q != TX_IDLE) begin
        if (bit_end) begin
          cnt_q <= '0;
          if (state_q == TX_DATA) begin
            shreg_q <= shreg_q >> 1;
            bit_q   <= last_data ? 3'd0 : bit_q + 3'd1;
          end else if (state_q == TX_STOP) begin
            bit_q <= bit_q + 3'd1;
          end
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      txd <= line_d;
      irq <= irq_en & fifo_empty & (state_q == TX_IDLE);
    end
  end

  // ---------------- register read ----------------
  tx_status_t  st;
  logic [31:0] rd_mux;

  always_comb begin
    st       = '0;
    st.busy  = ~fifo_empty | (state_q != TX_IDLE);
    st.empty = fifo_empty;
    st.ovf   = ovf;
    st.full  = fifo_full;
    st.level = 8'(fifo_level);
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_STATUS:  rd_mux = pack_status(st);
      REG_DIVIDER: rd_mux = {16'h0, divider};
      REG_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn)    rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: register table, hand-written framing
// corner cases, and random bursts decoded against a byte-queue model.
module tb_io_uart_tx;
  import io_pkg::*;

  localparam int DEPTH = 8;
  localparam int DIVR  = 48;
  localparam int STOPB = 1;

  logic        clk = 1'b0, resetn = 1'b0, sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        txd, irq;

  int tests = 0;
  int fails = 0;

  io_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR), .STOP_BITS(STOPB)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .reg_addr(reg_addr), .wdata(wdata),
    .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wstrb = 1'b1; reg_addr = a; wdata = d;
    step();
    sel = 1'b0; wstrb = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; rstrb = 1'b1; reg_addr = a;
    step();
    sel = 1'b0; rstrb = 1'b0;
    d = rdata;
  endtask

  // STATUS as the programmer sees it, from FIFO occupancy and activity
  function automatic logic [31:0] model_status(input int level, input bit active, input bit ovf);
    logic [31:0] s;
    s = 32'(level) << 16;
    if (level > 0 || active) s = s + 32'h1;
    if (level == 0)          s = s + 32'h2;
    if (ovf)                 s = s + 32'h8;
    if (level == DEPTH)      s = s + 32'h200;
    return s;
  endfunction

  // Steps until txd goes low; n = clks waited including the first low sample.
  task automatic wait_start(input string name, input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget) begin
      step();
      n++;
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s: no start bit within %0d clks", name, budget);
    end
  endtask

  // Called on the first low sample; checks every clk of the frame.
  task automatic check_frame(input string name, input logic [7:0] b, input int div);
    int bad;
    logic [7:0] rx;
    logic expb;
    bad = 0; rx = '0;
    for (int i = 0; i < 9 + STOPB; i++) begin
      for (int c = 0; c < div; c++) begin
        if (i != 0 || c != 0) step();
        expb = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1;
        if (txd !== expb) bad++;
        if (i >= 1 && i <= 8 && c == div / 2) rx[i-1] = txd;
      end
    end
    check({name, " data"}, {24'h0, rx}, {24'h0, b});
    check({name, " bad clks"}, bad, 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (txd !== 1'b1) bad++;
    end
    check(name, bad, 0);
  endtask

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdat;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[9];
    logic [31:0] r;
    logic [7:0]  q[$];
    logic [7:0]  expq[$];
    int          n, div, nb;
    bit          ok;

    // ---------------- reset ----------------
    repeat (3) step();
    check_bit("reset txd", txd, 1'b1);
    check_bit("reset irq", irq, 1'b0);
    check("reset rdata", rdata, 32'h0);
    resetn = 1'b1;
    step();
    rd(REG_STATUS, r);  check("reset status", r, model_status(0, 0, 0));
    rd(REG_DIVIDER, r); check("reset divider", r, DIVR);
    rd(REG_CTRL, r);    check("reset ctrl", r, 32'h0);

    // ---------------- register table ----------------
    vecs = '{
      '{REG_DIVIDER, 32'h0,         REG_DIVIDER, 32'h2},
      '{REG_DIVIDER, 32'h1,         REG_DIVIDER, 32'h2},
      '{REG_DIVIDER, 32'h2,         REG_DIVIDER, 32'h2},
      '{REG_DIVIDER, 32'hABCD_1234, REG_DIVIDER, 32'h1234},
      '{REG_DIVIDER, 32'h0000_FFFF, REG_DIVIDER, 32'hFFFF},
      '{REG_CTRL,    32'h7,         REG_CTRL,    32'h1},
      '{REG_CTRL,    32'hFFFF_FFFE, REG_CTRL,    32'h0},
      '{REG_DIVIDER, 32'd48,        REG_DATA,    32'h0},
      '{REG_CTRL,    32'h0,         REG_STATUS,  32'h2}
    };
    foreach (vecs[i]) begin
      wr(vecs[i].waddr, vecs[i].wdat);
      rd(vecs[i].raddr, r);
      check($sformatf("table[%0d]", i), r, vecs[i].exp);
    end

    rd(REG_DIVIDER, r);
    sel = 1'b1; reg_addr = REG_STATUS;
    step(); step();
    sel = 1'b0;
    check("rdata hold without rstrb", rdata, 32'd48);

    // ---------------- single 0x55 frame at divider 4 ----------------
    wr(REG_DIVIDER, 32'd4);
    wr(REG_DATA, 32'h55);
    wait_start("f55", 10, n, ok);
    check("f55 start latency", n, 2);
    if (ok) check_frame("f55", 8'h55, 4);
    quiet("f55 line idle", 5);

    // ---------------- overflow: 9 pushes while a frame is in flight ----------------
    fork
      begin
        wr(REG_DATA, 32'hA0);
        repeat (4) step();
        for (int k = 0; k < 9; k++) wr(REG_DATA, 32'h10 + k);
        rd(REG_STATUS, r);
        check("ovf status", r, model_status(DEPTH, 1, 1));
      end
      begin
        int m; bit g;
        wait_start("ovf f0", 10, m, g);
        if (g) check_frame("ovf f0", 8'hA0, 4);
        for (int k = 0; k < 8; k++) begin
          wait_start("ovf fk", 10, m, g);
          check($sformatf("ovf gap %0d", k), m, 2);
          if (g) check_frame($sformatf("ovf f%0d", k + 1), 8'(8'h10 + k), 4);
        end
      end
    join
    quiet("ovf no 9th frame", 60);
    rd(REG_STATUS, r); check("ovf sticky", r, model_status(0, 0, 1));
    wr(REG_CTRL, 32'h4);
    rd(REG_STATUS, r); check("ovf cleared", r, model_status(0, 0, 0));

    // ---------------- divider change mid-frame ----------------
    fork
      begin
        wr(REG_DATA, 32'hC3);
        wr(REG_DATA, 32'h3C);
        repeat (10) step();
        wr(REG_DIVIDER, 32'd8);
      end
      begin
        int m; bit g;
        wait_start("div f1", 10, m, g);
        if (g) check_frame("div f1", 8'hC3, 4);
        wait_start("div f2", 10, m, g);
        check("div gap", m, 2);
        if (g) check_frame("div f2", 8'h3C, 8);
      end
    join
    rd(REG_DIVIDER, r); check("div readback 8", r, 32'd8);
    wr(REG_DIVIDER, 32'd0);
    rd(REG_DIVIDER, r); check("div clamp 0", r, 32'd2);
    wr(REG_DIVIDER, 32'd4);

    // ---------------- flush during first frame ----------------
    fork
      begin
        for (int k = 0; k < 4; k++) wr(REG_DATA, 32'hE0 + k);
        repeat (5) step();
        wr(REG_CTRL, 32'h2);
      end
      begin
        int m; bit g;
        wait_start("flush f0", 10, m, g);
        if (g) check_frame("flush f0", 8'hE0, 4);
      end
    join
    quiet("flush no more frames", 60);
    rd(REG_STATUS, r); check("flush status", r, 32'h0000_0002);

    // ---------------- irq ----------------
    wr(REG_CTRL, 32'h1);
    step();
    check_bit("irq idle enabled", irq, 1'b1);
    wr(REG_DATA, 32'h81);
    wait_start("irq f", 10, n, ok);
    check_bit("irq low while busy", irq, 1'b0);
    if (ok) check_frame("irq f", 8'h81, 4);
    check_bit("irq during last stop clk", irq, 1'b0);
    step();
    check_bit("irq after stop", irq, 1'b1);
    wr(REG_CTRL, 32'h0);
    step();
    check_bit("irq disabled", irq, 1'b0);

    // ---------------- reset mid data bit ----------------
    wr(REG_CTRL, 32'h1);
    wr(REG_DATA, 32'h00);
    wr(REG_DATA, 32'h5A);
    wr(REG_DATA, 32'h5A);
    wait_start("rst f", 10, n, ok);
    repeat (10) step();
    check_bit("rst mid data low", txd, 1'b0);
    resetn = 1'b0;
    step();
    check_bit("rst txd high", txd, 1'b1);
    check_bit("rst irq low", irq, 1'b0);
    check("rst rdata", rdata, 32'h0);
    resetn = 1'b1;
    rd(REG_STATUS, r);  check("rst status", r, 32'h0000_0002);
    rd(REG_DIVIDER, r); check("rst divider", r, DIVR);
    rd(REG_CTRL, r);    check("rst ctrl", r, 32'h0);
    quiet("rst fifo discarded", 60);

    // ---------------- random bursts vs byte-queue model ----------------
    for (int t = 0; t < 8; t++) begin
      div = $urandom_range(2, 6);
      nb  = $urandom_range(1, 6);
      q.delete();
      for (int k = 0; k < nb; k++) q.push_back(8'($urandom_range(0, 255)));
      expq = q;
      wr(REG_DIVIDER, div);
      fork
        begin
          for (int k = 0; k < nb; k++) wr(REG_DATA, {24'h0, q[k]});
        end
        begin
          int m; bit g;
          logic [7:0] eb;
          for (int k = 0; k < nb; k++) begin
            wait_start("rnd start", 20, m, g);
            if (k > 0) check($sformatf("rnd %0d gap", t), m, 2);
            eb = expq.pop_front();
            if (g) check_frame($sformatf("rnd %0d f%0d", t, k), eb, div);
          end
        end
      join
      rd(REG_STATUS, r);
      check($sformatf("rnd %0d status", t), r, model_status(expq.size(), 0, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
